// File: rtl/mist1032sa_fifo_drain_if.sv
// Handshake bundle between a show-ahead FIFO, the drain buffer and its consumer.
// The master side is the environment (FIFO + consumer) and the slave side is the drain stage.
interface mist1032sa_fifo_drain_if #(
  parameter int N = 16
);
  logic         iREMOVE;
  logic         iFIFO_EMPTY;
  logic [N-1:0] iFIFO_DATA;
  logic         oFIFO_RD_EN;
  logic         oVALID;
  logic [N-1:0] oDATA;
  logic         iBUSY;
  logic [1:0]   oBUF_COUNT;
  logic         oIDLE;

  modport master (
    output iREMOVE, iFIFO_EMPTY, iFIFO_DATA, iBUSY,
    input  oFIFO_RD_EN, oVALID, oDATA, oBUF_COUNT, oIDLE
  );

  modport slave (
    input  iREMOVE, iFIFO_EMPTY, iFIFO_DATA, iBUSY,
    output oFIFO_RD_EN, oVALID, oDATA, oBUF_COUNT, oIDLE
  );
endinterface

// File: rtl/mist1032sa_fifo_drain.sv
// Two-entry drain buffer between a show-ahead FIFO and a valid/busy consumer.
// Optional zero-latency bypass when empty: define MIST1032SA_FIFO_DRAIN_BYPASS_EN.
module mist1032sa_fifo_drain #(
  parameter int N = 16
) (
  input  logic                   iCLOCK,
  input  logic                   iRESET,
  mist1032sa_fifo_drain_if.slave bus
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [1:0]   b_count_q, b_count_d;
  logic [N-1:0] b_slot0_q, b_slot0_d;
  logic [N-1:0] b_slot1_q, b_slot1_d;
  logic         pop;
  logic         take;
  logic         valid;
  logic [N-1:0] data;

  // The read enable sees only buffer occupancy and FIFO flags, so a consumer
  // stall never reaches the FIFO combinationally.
  assign pop = !bus.iREMOVE && !bus.iFIFO_EMPTY && (b_count_q != ST_FULL);

`ifdef MIST1032SA_FIFO_DRAIN_BYPASS_EN
  logic bypass;
  assign bypass = (b_count_q == ST_EMPTY) && !bus.iFIFO_EMPTY && !bus.iREMOVE;
  assign valid  = ((b_count_q != ST_EMPTY) || bypass) && !bus.iREMOVE;
  assign data   = bypass ? bus.iFIFO_DATA : b_slot0_q;
`else
  assign valid  = (b_count_q != ST_EMPTY) && !bus.iREMOVE;
  assign data   = b_slot0_q;
`endif

  assign take = valid && !bus.iBUSY;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    b_count_d = b_count_q;
    b_slot0_d = b_slot0_q;
    b_slot1_d = b_slot1_q;
    if (bus.iREMOVE) begin
      b_count_d = ST_EMPTY;
    end else begin
      case (b_count_q)
        // With bypass, pop && take in EMPTY consumes the word without storing it.
        ST_EMPTY: begin
          if (pop && !take) begin
            b_count_d = ST_ONE;
            b_slot0_d = bus.iFIFO_DATA;
          end
        end
        ST_ONE: begin
          if (pop && take) begin
            b_slot0_d = bus.iFIFO_DATA;
          end else if (pop) begin
            b_count_d = ST_FULL;
            b_slot1_d = bus.iFIFO_DATA;
          end else if (take) begin
            b_count_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (take) begin
            b_count_d = ST_ONE;
            b_slot0_d = b_slot1_q;
          end
        end
        default: b_count_d = ST_EMPTY;
      endcase
    end
  end

  // NOTE: the two slots are plain flops, so resetting them is cheap and keeps oDATA defined.
  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      b_count_q <= ST_EMPTY;
      b_slot0_q <= '0;
      b_slot1_q <= '0;
    end else begin
      b_count_q <= b_count_d;
      b_slot0_q <= b_slot0_d;
      b_slot1_q <= b_slot1_d;
    end
  end

  assign bus.oFIFO_RD_EN = pop;
  assign bus.oVALID      = valid;
  assign bus.oDATA       = data;
  assign bus.oBUF_COUNT  = b_count_q;
  assign bus.oIDLE       = (b_count_q == ST_EMPTY) && bus.iFIFO_EMPTY;

endmodule

// File: tb/tb_mist1032sa_fifo_drain.sv
// Directed and randomized-stall bench for mist1032sa_fifo_drain with a queue-based FIFO
// and an in-order scoreboard of every word handed to the consumer.
module tb_mist1032sa_fifo_drain;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mist1032sa_fifo_drain_if #(.N(16)) bus ();

  mist1032sa_fifo_drain #(.N(16)) dut (
    .iCLOCK (clk),
    .iRESET (rst),
    .bus    (bus)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  int          n_xfer   = 0;
  int          base;
  int          guard;
  logic [15:0] fifo_q[$];
  logic [15:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive_fifo();
    bus.iFIFO_EMPTY = (fifo_q.size() == 0);
    bus.iFIFO_DATA  = (fifo_q.size() != 0) ? fifo_q[0] : 16'h0000;
  endtask

  task automatic push(input logic [15:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
    drive_fifo();
  endtask

  // Called at a falling edge: checks the settled cycle, clocks it, then moves the FIFO model.
  task automatic cycle();
    logic popped;
    logic removed;
    #1;
    check("no_pop_empty", 32'(bus.oFIFO_RD_EN && bus.iFIFO_EMPTY), 0);
    check("count_range", 32'(bus.oBUF_COUNT == 2'd3), 0);
    if (bus.oVALID && !bus.iBUSY) begin
      n_xfer++;
      if (exp_q.size() == 0) check("xfer_extra", 1, 0);
      else                   check("xfer_data", 32'(bus.oDATA), 32'(exp_q.pop_front()));
    end
    popped  = bus.oFIFO_RD_EN;
    removed = bus.iREMOVE;
    @(posedge clk);
    if (removed) begin
      fifo_q.delete();
      exp_q.delete();
    end else if (popped && fifo_q.size() != 0) begin
      void'(fifo_q.pop_front());
    end
    #1 drive_fifo();
    @(negedge clk);
  endtask

  initial begin
    rst         = 1'b1;
    bus.iREMOVE = 1'b0;
    bus.iBUSY   = 1'b0;
    drive_fifo();
    #1;
    check("rst_valid", 32'(bus.oVALID), 0);
    check("rst_count", 32'(bus.oBUF_COUNT), 0);
    check("rst_rd_en", 32'(bus.oFIFO_RD_EN), 0);
    check("rst_idle", 32'(bus.oIDLE), 1);
    check("rst_data", 32'(bus.oDATA), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Three words streamed with no stall.
    push(16'h1111);
    push(16'h2222);
    push(16'h3333);
    #1;
    check("t1_rd_en", 32'(bus.oFIFO_RD_EN), 1);
`ifdef MIST1032SA_FIFO_DRAIN_BYPASS_EN
    check("t1_byp_valid", 32'(bus.oVALID), 1);
    check("t1_byp_data", 32'(bus.oDATA), 32'h1111);
    cycle();
    #1;
    check("t1_data2", 32'(bus.oDATA), 32'h2222);
    check("t1_count", 32'(bus.oBUF_COUNT), 0);
`else
    check("t1_valid_pre", 32'(bus.oVALID), 0);
    cycle();
    #1;
    check("t1_data1", 32'(bus.oDATA), 32'h1111);
    check("t1_count", 32'(bus.oBUF_COUNT), 1);
`endif
    repeat (3) cycle();
    check("t1_idle", 32'(bus.oIDLE), 1);
    check("t1_xfers", 32'(n_xfer), 3);

    // Consumer stalled with five words queued: only two are absorbed.
    bus.iBUSY = 1'b1;
    for (int i = 1; i <= 5; i++) push(16'hA000 + 16'(i));
    repeat (4) cycle();
    #1;
    check("t2_count", 32'(bus.oBUF_COUNT), 2);
    check("t2_rd_en", 32'(bus.oFIFO_RD_EN), 0);
    check("t2_valid", 32'(bus.oVALID), 1);
    check("t2_data", 32'(bus.oDATA), 32'hA001);
    check("t2_fifo_left", 32'(fifo_q.size()), 3);
    bus.iBUSY = 1'b0;
    base = n_xfer;
    repeat (6) cycle();
    check("t2_xfers", 32'(n_xfer - base), 5);
    check("t2_idle", 32'(bus.oIDLE), 1);

    // Pop and take together in ONE.
    bus.iBUSY = 1'b1;
    push(16'hAAAA);
    cycle();
    bus.iBUSY = 1'b0;
    push(16'hBBBB);
    #1;
    check("t3_valid", 32'(bus.oVALID), 1);
    check("t3_data_a", 32'(bus.oDATA), 32'hAAAA);
    check("t3_rd_en", 32'(bus.oFIFO_RD_EN), 1);
    cycle();
    #1;
    check("t3_data_b", 32'(bus.oDATA), 32'hBBBB);
    check("t3_count", 32'(bus.oBUF_COUNT), 1);
    repeat (2) cycle();
    check("t3_idle", 32'(bus.oIDLE), 1);

    // Flush while FULL, consumer ready.
    bus.iBUSY = 1'b1;
    push(16'h0001);
    push(16'h0002);
    repeat (2) cycle();
    #1;
    check("t4_full", 32'(bus.oBUF_COUNT), 2);
    base        = n_xfer;
    bus.iBUSY   = 1'b0;
    bus.iREMOVE = 1'b1;
    #1;
    check("t4_rm_valid", 32'(bus.oVALID), 0);
    check("t4_rm_rd_en", 32'(bus.oFIFO_RD_EN), 0);
    cycle();
    bus.iREMOVE = 1'b0;
    #1;
    check("t4_count", 32'(bus.oBUF_COUNT), 0);
    check("t4_valid", 32'(bus.oVALID), 0);
    check("t4_no_xfer", 32'(n_xfer - base), 0);

    // Flush while ONE with a non-empty FIFO: the pop is suppressed too.
    bus.iBUSY = 1'b1;
    push(16'h0005);
    cycle();
    push(16'h0006);
    bus.iBUSY   = 1'b0;
    bus.iREMOVE = 1'b1;
    #1;
    check("t4b_rd_en", 32'(bus.oFIFO_RD_EN), 0);
    check("t4b_valid", 32'(bus.oVALID), 0);
    cycle();
    bus.iREMOVE = 1'b0;
    #1;
    check("t4b_count", 32'(bus.oBUF_COUNT), 0);
    check("t4b_idle", 32'(bus.oIDLE), 1);

    // Asynchronous reset between edges while FULL.
    bus.iBUSY = 1'b1;
    push(16'h5A5A);
    push(16'hA5A5);
    repeat (2) cycle();
    #1;
    check("t5_full", 32'(bus.oBUF_COUNT), 2);
    #1 rst = 1'b1;
    #1;
    check("t5_valid", 32'(bus.oVALID), 0);
    check("t5_count", 32'(bus.oBUF_COUNT), 0);
    check("t5_data", 32'(bus.oDATA), 0);
    fifo_q.delete();
    exp_q.delete();
    drive_fifo();
    @(negedge clk);
    @(negedge clk);
    rst       = 1'b0;
    bus.iBUSY = 1'b0;
    #1;
    check("t5_idle", 32'(bus.oIDLE), 1);

    // 1000 words under a random 50% stall.
    base = n_xfer;
    for (int i = 0; i < 1000; i++) push(16'($urandom));
    guard = 0;
    while (exp_q.size() != 0 && guard < 20000) begin
      bus.iBUSY = 1'($urandom_range(0, 1));
      cycle();
      guard++;
    end
    check("t6_drained", 32'(exp_q.size()), 0);
    check("t6_xfers", 32'(n_xfer - base), 1000);
    bus.iBUSY = 1'b0;
    repeat (2) cycle();
    check("t6_idle", 32'(bus.oIDLE), 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
